// File: rtl/mul_div_seq_if.sv
// Request/result bundle for the multi-cycle multiply/divide sequencer.
// The master drives the request side and the slave returns busy/done and HI/LO.
interface mul_div_seq_if #(
  parameter int unsigned Width = 32
);
  logic             start;
  logic             op;
  logic [Width-1:0] x;
  logic [Width-1:0] y;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [Width-1:0] hi;
  logic [Width-1:0] lo;

  modport master (
    output start, op, x, y,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, x, y,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_seq.sv
// Signed multiply (radix-2 Booth) / divide (restoring on magnitudes) sequencer
// for the HI/LO path; one iteration per cycle, results held until the next DONE.
module mul_div_seq #(
  parameter int unsigned Width = 32
) (
  input logic          clock_i,
  input logic          clear_i,
  mul_div_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(Width);

  typedef enum logic [2:0] {StIdle, StMulRun, StDivRun, StDivFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // a_q is one bit wider than an operand so Booth add/sub of the most negative Y
  // cannot overflow; in divide it holds the partial remainder.
  logic [Width:0]   a_q, a_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width-1:0] y_q, y_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [Width-1:0] lo_q, lo_d;
  logic             e_q, e_d;
  logic             x_neg_q, x_neg_d;
  logic             y_neg_q, y_neg_d;
  logic             dbz_q, dbz_d;

  logic [Width:0]   booth_sum;
  logic [Width:0]   div_shift;
  logic [Width:0]   div_trial;
  logic             last_iter;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    q_d       = q_q;
    y_d       = y_q;
    e_d       = e_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    x_neg_d   = x_neg_q;
    y_neg_d   = y_neg_q;
    dbz_d     = dbz_q;
    last_iter = (cnt_q == CntW'(Width - 1));

    case ({q_q[0], e_q})
      2'b01:   booth_sum = a_q + {y_q[Width-1], y_q};
      2'b10:   booth_sum = a_q - {y_q[Width-1], y_q};
      default: booth_sum = a_q;
    endcase
    div_shift = {a_q[Width-1:0], q_q[Width-1]};
    div_trial = div_shift - {1'b0, y_q};

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d   = '0;
          dbz_d   = 1'b0;
          a_d     = '0;
          e_d     = 1'b0;
          x_neg_d = bus.x[Width-1];
          y_neg_d = bus.y[Width-1];
          if (!bus.op) begin
            q_d     = bus.x;
            y_d     = bus.y;
            state_d = StMulRun;
          end else if (bus.y == '0) begin
            hi_d    = bus.x;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            q_d     = bus.x[Width-1] ? -bus.x : bus.x;
            y_d     = bus.y[Width-1] ? -bus.y : bus.y;
            state_d = StDivRun;
          end
        end
      end
      StMulRun: begin
        // Arithmetic right shift of {A, Q, E} after the Booth add/sub.
        a_d   = {booth_sum[Width], booth_sum[Width:1]};
        q_d   = {booth_sum[0], q_q[Width-1:1]};
        e_d   = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          hi_d    = booth_sum[Width:1];
          lo_d    = {booth_sum[0], q_q[Width-1:1]};
          state_d = StDone;
        end
      end
      StDivRun: begin
        // Dividend bits leave the top of q_q as quotient bits enter the bottom.
        a_d   = div_trial[Width] ? div_shift : div_trial;
        q_d   = {q_q[Width-2:0], ~div_trial[Width]};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = StDivFix;
        end
      end
      StDivFix: begin
        lo_d    = (x_neg_q ^ y_neg_q) ? -q_q : q_q;
        hi_d    = x_neg_q ? -a_q[Width-1:0] : a_q[Width-1:0];
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      y_q     <= '0;
      e_q     <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      x_neg_q <= 1'b0;
      y_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      y_q     <= y_d;
      e_q     <= e_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      x_neg_q <= x_neg_d;
      y_neg_q <= y_neg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: a latency/arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mul_div_seq;

  logic clock = 1'b0;
  logic clear = 1'b1;

  mul_div_seq_if #(.Width(32)) bus ();

  mul_div_seq #(.Width(32)) dut (
    .clock_i (clock),
    .clear_i (clear),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference state: what the outputs must show in the cycle after each edge.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_dbz  = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [64:0] m_pend = '0;
  int          m_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {div_by_zero, HI, LO} from plain integer arithmetic.
  function automatic logic [64:0] model_result(input logic o, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint p;
    longint qq;
    longint rr;
    if (!o) begin
      p = sa * sb;
      return {1'b0, p[63:0]};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    qq = sa / sb;
    rr = sa % sb;
    return {1'b0, rr[31:0], qq[31:0]};
  endfunction

  always @(posedge clock) begin
    if (clear) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_pend = model_result(bus.op, bus.x, bus.y);
        m_busy = 1'b1;
        m_dbz  = 1'b0;
        m_left = !bus.op ? 32 : (bus.y == 32'd0 ? 0 : 33);
        if (m_left == 0) begin
          m_done = 1'b1;
          {m_dbz, m_hi, m_lo} = m_pend;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        {m_dbz, m_hi, m_lo} = m_pend;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  // Called just after an accept edge; returns at the negedge where done is seen.
  task automatic wait_done(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      cyc++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string nm, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic edbz, input int elat);
    int cyc;
    bit ok;
    bus.start = 1'b1; bus.op = o; bus.x = a; bus.y = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0; bus.op = ~o; bus.x = $urandom; bus.y = $urandom;
    wait_done(cyc, ok);
    check({nm, "_latency"}, 32'(cyc), 32'(elat));
    if (ok) begin
      check({nm, "_hi"}, bus.hi, eh);
      check({nm, "_lo"}, bus.lo, el);
      check({nm, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cyc;
    int pulses;
    bit ok;
    bus.start = 1'b0; bus.op = 1'b0; bus.x = '0; bus.y = '0;
    repeat (2) @(posedge clock);
    #1;
    clear  = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    @(posedge clock);
    #1;

    run_op("mul_7_m3", 1'b0, 32'd7, -32'sd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
    run_op("mul_max_m1", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001,
           1'b0, 33);
    run_op("div_m7_2", 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
    run_op("div_100_m7", 1'b1, 32'd100, -32'sd7, 32'd2, 32'hFFFF_FFF2, 1'b0, 34);
    run_op("div_m100_m7", 1'b1, -32'sd100, -32'sd7, 32'hFFFF_FFFE, 32'd14, 1'b0, 34);
    run_op("div_5_0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);

    // Next MUL accept must drop div_by_zero immediately.
    bus.start = 1'b1; bus.op = 1'b0; bus.x = 32'd6; bus.y = -32'sd5;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    @(negedge clock);
    check("dbz_cleared_on_accept", 32'(bus.div_by_zero), 32'd0);
    wait_done(cyc, ok);
    check("mul_6_m5_latency", 32'(cyc + 1), 32'd33);
    check("mul_6_m5_lo", bus.lo, 32'hFFFF_FFE2);
    @(posedge clock);
    #1;

    // Start pulses mid-run and in the DONE cycle must be ignored.
    bus.start = 1'b1; bus.op = 1'b0; bus.x = 32'd9; bus.y = -32'sd11;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    bus.start = 1'b1; bus.op = 1'b1; bus.x = 32'd1234; bus.y = 32'd7;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_done(cyc, ok);
    check("busy_start_hi", bus.hi, 32'hFFFF_FFFF);
    check("busy_start_lo", bus.lo, 32'hFFFF_FF9D);
    bus.start = 1'b1; bus.op = 1'b0; bus.x = 32'd2; bus.y = 32'd2;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) pulses++;
    end
    check("no_second_done", 32'(pulses), 32'd0);
    @(posedge clock);
    #1;

    // Clear in the middle of a divide discards it.
    bus.start = 1'b1; bus.op = 1'b1; bus.x = 32'd1000; bus.y = 32'd3;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("clear_busy", 32'(bus.busy), 32'd0);
    check("clear_done", 32'(bus.done), 32'd0);
    check("clear_hi", bus.hi, 32'd0);
    check("clear_lo", bus.lo, 32'd0);
    @(posedge clock);
    #1;
    run_op("mul_3_4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33);
    run_op("div_1000_3", 1'b1, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 34);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
